// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, saturating shift counter.
// Optional rotate feature enabled by defining USR_ROTATE_EN; otherwise rot is ignored.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic                       sin_msb,
  input  logic                       sin_lsb,
  input  logic [WIDTH-1:0]           d,
  input  logic                       rot,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_lsb,
  output logic                       sout_msb,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       drained
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_t;

  logic fill_msb;
  logic fill_lsb;

`ifdef USR_ROTATE_EN
  assign fill_msb = rot ? q[0]       : sin_msb;
  assign fill_lsb = rot ? q[WIDTH-1] : sin_lsb;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill_msb   = sin_msb;
  assign fill_lsb   = sin_lsb;
`endif

  // Counter saturates at WIDTH; both shift directions count up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q   <= '0;
      cnt <= '0;
    end else if (clr) begin
      q   <= '0;
      cnt <= '0;
    end else if (en) begin
      case (mode_t'(mode))
        MODE_RIGHT: begin
          q <= {fill_msb, q[WIDTH-1:1]};
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
        MODE_LEFT: begin
          q <= {q[WIDTH-2:0], fill_lsb};
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
        MODE_LOAD: begin
          q   <= d;
          cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign sout_lsb = q[0];
  assign sout_msb = q[WIDTH-1];
  assign drained  = (cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios plus randomized traffic vs. an arithmetic model.
module tb_univ_shift_reg;
  localparam int W = 8;
`ifdef USR_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         en, clr, sin_msb, sin_lsb, rot;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         sout_lsb, sout_msb, drained;
  logic [3:0]   cnt;

  int total = 0;
  int bad   = 0;
  int unsigned mq = 0;
  int unsigned mc = 0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .d(d), .rot(rot),
    .q(q), .sout_lsb(sout_lsb), .sout_msb(sout_msb), .cnt(cnt), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour expressed as integer arithmetic on the register value.
  task automatic modelEdge(input logic e, input logic c, input logic [1:0] m,
                           input logic sm, input logic sl, input logic [W-1:0] dv, input logic r);
    int unsigned bitIn;
    int unsigned mask = (1 << W) - 1;
    if (c) begin
      mq = 0; mc = 0;
    end else if (e) begin
      if (m == 2'd1) begin
        bitIn = (ROT_EN && r) ? (mq % 2) : int'(sm);
        mq = (mq / 2) + bitIn * (1 << (W-1));
        mc = (mc < W) ? mc + 1 : W;
      end else if (m == 2'd2) begin
        bitIn = (ROT_EN && r) ? (mq / (1 << (W-1))) : int'(sl);
        mq = (mq * 2 + bitIn) & mask;
        mc = (mc < W) ? mc + 1 : W;
      end else if (m == 2'd3) begin
        mq = dv; mc = 0;
      end
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".q"}, 32'(q), 32'(mq));
    checkOutput({tag, ".cnt"}, 32'(cnt), 32'(mc));
    checkOutput({tag, ".drained"}, 32'(drained), 32'(mc == W));
    checkOutput({tag, ".sout_lsb"}, 32'(sout_lsb), 32'(mq % 2));
    checkOutput({tag, ".sout_msb"}, 32'(sout_msb), 32'(mq / (1 << (W-1))));
  endtask

  task automatic applyStimulus(input string tag, input logic e, input logic c, input logic [1:0] m,
                               input logic sm, input logic sl, input logic [W-1:0] dv, input logic r);
    @(negedge clk);
    en = e; clr = c; mode = m; sin_msb = sm; sin_lsb = sl; d = dv; rot = r;
    @(posedge clk);
    modelEdge(e, c, m, sm, sl, dv, r);
    #1;
    checkAll(tag);
  endtask

  initial begin
    en = 0; clr = 0; mode = 0; sin_msb = 0; sin_lsb = 0; d = 0; rot = 0;
    reset = 1'b0;
    #12;
    checkAll("reset_init");
    reset = 1'b1;

    // Test 1: asynchronous reset between edges with a pending load
    applyStimulus("t1_load", 1, 0, 2'd3, 0, 0, 8'hA5, 0);
    checkOutput("t1_pre_reset_q", 32'(q), 32'hA5);
    @(negedge clk);
    en = 1; mode = 2'd3; d = 8'hFF;
    #2 reset = 1'b0;
    #1;
    mq = 0; mc = 0;
    checkAll("t1_async");
    @(posedge clk); #1;
    checkAll("t1_held_in_reset");
    @(negedge clk);
    reset = 1'b1; en = 0;

    // Test 2: load then three right shifts filling ones
    applyStimulus("t2_load", 1, 0, 2'd3, 0, 0, 8'hA5, 0);
    for (int i = 0; i < 3; i++) applyStimulus("t2_shr", 1, 0, 2'd1, 1, 0, 8'h00, 0);
    checkOutput("t2_q", 32'(q), 32'hF4);
    checkOutput("t2_cnt", 32'(cnt), 32'd3);
    checkOutput("t2_sout_lsb", 32'(sout_lsb), 32'd0);

    // Test 3: ten left shifts saturate the counter at WIDTH
    applyStimulus("t3_load", 1, 0, 2'd3, 0, 0, 8'h81, 0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus("t3_shl", 1, 0, 2'd2, 0, 0, 8'h00, 0);
      if (i >= 8) begin
        checkOutput("t3_q_zero", 32'(q), 32'h00);
        checkOutput("t3_drained", 32'(drained), 32'd1);
        checkOutput("t3_cnt_sat", 32'(cnt), 32'd8);
      end
    end

    // Test 4: clear beats load, then disabled shifts hold
    applyStimulus("t4_clr", 1, 1, 2'd3, 0, 0, 8'hFF, 0);
    checkOutput("t4_q", 32'(q), 32'h00);
    applyStimulus("t4_load", 1, 0, 2'd3, 0, 0, 8'h5A, 0);
    for (int i = 0; i < 4; i++) applyStimulus("t4_hold", 0, 0, 2'd1, 1, 1, 8'h00, 0);
    checkOutput("t4_q_held", 32'(q), 32'h5A);
    @(negedge clk);
    mode = 'x; d = 'x; sin_msb = 'x; sin_lsb = 'x; rot = 'x; en = 0; clr = 0;
    @(posedge clk); #1;
    checkAll("t4_x_hold");

    // Test 5: rotate (or plain shift when rotate is not built in)
    applyStimulus("t5_load", 1, 0, 2'd3, 0, 0, 8'h01, 1);
    applyStimulus("t5_shr", 1, 0, 2'd1, 0, 0, 8'h00, 1);
    checkOutput("t5_q_after_shr", 32'(q), ROT_EN ? 32'h80 : 32'h00);
    for (int i = 0; i < 8; i++) applyStimulus("t5_shl", 1, 0, 2'd2, 0, 0, 8'h00, 1);
    checkOutput("t5_q_after_shl", 32'(q), ROT_EN ? 32'h80 : 32'h00);
    checkOutput("t5_cnt", 32'(cnt), 32'd8);

    // Test 6: load after shifts resets the counter
    for (int i = 0; i < 5; i++) applyStimulus("t6_shift", 1, 0, 2'd1, 1, 0, 8'h00, 0);
    applyStimulus("t6_load", 1, 0, 2'd3, 0, 0, 8'h3C, 0);
    checkOutput("t6_q", 32'(q), 32'h3C);
    checkOutput("t6_cnt", 32'(cnt), 32'd0);
    checkOutput("t6_drained", 32'(drained), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                    2'($urandom), 1'($urandom), 1'($urandom), W'($urandom), 1'($urandom));
    end

    $display("[TB] random phase complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
